// File: rtl/sdram_uart_cmd_pkg.sv
// Shared constants for the UART command bridge: opcodes, reply bytes,
// FSM state encoding and per-opcode argument byte counts.
package sdram_uart_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_BURST = 8'h42;

  localparam logic [7:0] RPL_OK  = 8'h4B;
  localparam logic [7:0] RPL_BAD = 8'h3F;
  localparam logic [7:0] RPL_TMO = 8'h54;

  localparam logic [2:0] NARG_WRITE = 3'd5;
  localparam logic [2:0] NARG_READ  = 3'd3;
  localparam logic [2:0] NARG_BURST = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_TX
  } state_t;

  // Zero marks an opcode the bridge does not understand.
  function automatic logic [2:0] arg_count(input logic [7:0] op);
    case (op)
      OP_WRITE: return NARG_WRITE;
      OP_READ:  return NARG_READ;
      OP_BURST: return NARG_BURST;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sdram_uart_cmd_if.sv
// Logical access port between the command bridge (master) and sdram_ctrl (slave).
interface sdram_uart_cmd_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] sd_addr;
  logic [DATA_WIDTH-1:0] sd_wr_data;
  logic [DATA_WIDTH-1:0] sd_rd_data;
  logic                  sd_we;
  logic                  sd_enable;
  logic                  sd_ack;
  logic                  sd_idle;

  modport master (
    output sd_addr, sd_wr_data, sd_we, sd_enable,
    input  sd_rd_data, sd_ack, sd_idle
  );

  modport slave (
    input  sd_addr, sd_wr_data, sd_we, sd_enable,
    output sd_rd_data, sd_ack, sd_idle
  );
endinterface

// File: rtl/sdram_uart_cmd_timeout.sv
// Inter-byte timeout: loadable down-counter that flags expiry while enabled.
module uart_timeout #(
  parameter int TIMEOUT = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (reload) begin
      r_cnt <= CW'(TIMEOUT);
    end else if (enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign expired = enable && (r_cnt == '0);

endmodule

// File: rtl/sdram_uart_cmd.sv
// Host command bridge: parses W/R/B frames from the UART, issues SDRAM
// accesses through the logical port and returns acks or read data.
module sdram_uart_cmd
  import sdram_uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 120000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rxd,
  input  logic             rxd_strobe,
  output logic [7:0]       txd,
  output logic             txd_strobe,
  input  logic             txd_ready,
  sdram_uart_cmd_if.master sd,
  output logic             busy,
  output logic             overrun
);
  localparam int SHW = ADDR_WIDTH + DATA_WIDTH;

  state_t                r_state, w_state_n;
  logic [7:0]            r_op, w_op_n;
  logic [2:0]            r_argcnt, w_argcnt_n;
  logic [SHW-9:0]        r_args, w_args_n;
  logic [SHW-1:0]        w_shift;
  logic [7:0]            r_txd, w_txd_n;
  logic                  r_txd_strobe, w_txd_strobe_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n;
  logic                  r_we, w_we_n;
  logic                  r_en, w_en_n;
  logic                  r_busy, w_busy_n;
  logic                  r_overrun, w_overrun_n;
  logic [DATA_WIDTH-1:0] r_buf, w_buf_n;
  logic [1:0]            r_txleft, w_txleft_n;
  logic [7:0]            r_words, w_words_n;
  logic                  w_reload, w_tmo_en, w_expired, w_last;

  assign w_tmo_en = (r_state == S_ARG);

  uart_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (reset),
    .reload  (w_reload),
    .enable  (w_tmo_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_argcnt     <= '0;
      r_args       <= '0;
      r_txd        <= '0;
      r_txd_strobe <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_buf        <= '0;
      r_txleft     <= '0;
      r_words      <= '0;
    end else begin
      r_state      <= w_state_n;
      r_op         <= w_op_n;
      r_argcnt     <= w_argcnt_n;
      r_args       <= w_args_n;
      r_txd        <= w_txd_n;
      r_txd_strobe <= w_txd_strobe_n;
      r_addr       <= w_addr_n;
      r_wdata      <= w_wdata_n;
      r_we         <= w_we_n;
      r_en         <= w_en_n;
      r_busy       <= w_busy_n;
      r_overrun    <= w_overrun_n;
      r_buf        <= w_buf_n;
      r_txleft     <= w_txleft_n;
      r_words      <= w_words_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_op_n         = r_op;
    w_argcnt_n     = r_argcnt;
    w_args_n       = r_args;
    w_txd_n        = r_txd;
    w_txd_strobe_n = 1'b0;
    w_addr_n       = r_addr;
    w_wdata_n      = r_wdata;
    w_we_n         = r_we;
    w_en_n         = r_en;
    w_overrun_n    = r_overrun;
    w_buf_n        = r_buf;
    w_txleft_n     = r_txleft;
    w_words_n      = r_words;
    w_reload       = 1'b0;
    w_shift        = {r_args, rxd};
    w_last         = ((r_argcnt + 3'd1) == arg_count(r_op));

    case (r_state)
      S_IDLE: begin
        if (rxd_strobe) begin
          w_op_n     = rxd;
          w_argcnt_n = '0;
          if (arg_count(rxd) != 3'd0) begin
            w_reload  = 1'b1;
            w_state_n = S_ARG;
          end else begin
            w_buf_n    = DATA_WIDTH'(RPL_BAD);
            w_txleft_n = 2'd1;
            w_state_n  = S_TX;
          end
        end
      end
      S_ARG: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (rxd_strobe) begin
          w_args_n   = w_shift[SHW-9:0];
          w_argcnt_n = r_argcnt + 3'd1;
          w_reload   = 1'b1;
          if (w_last) begin
            w_state_n = S_MEM_REQ;
            w_words_n = '0;
            w_we_n    = 1'b0;
            case (r_op)
              OP_WRITE: begin
                w_addr_n  = w_shift[SHW-1:DATA_WIDTH];
                w_wdata_n = w_shift[DATA_WIDTH-1:0];
                w_we_n    = 1'b1;
              end
              OP_BURST: begin
                w_addr_n  = w_shift[ADDR_WIDTH+7:8];
                w_words_n = w_shift[7:0];
              end
              default: w_addr_n = w_shift[ADDR_WIDTH-1:0];
            endcase
          end
        end else if (w_expired) begin
          w_buf_n    = DATA_WIDTH'(RPL_TMO);
          w_txleft_n = 2'd1;
          w_state_n  = S_TX;
        end
      end
      S_MEM_REQ: begin
        if (sd.sd_idle) begin
          w_en_n    = 1'b1;
          w_state_n = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (sd.sd_ack) begin
          w_en_n    = 1'b0;
          w_state_n = S_TX;
          if (r_we) begin
            w_buf_n    = DATA_WIDTH'(RPL_OK);
            w_txleft_n = 2'd1;
          end else begin
            w_buf_n    = sd.sd_rd_data;
            w_txleft_n = 2'd2;
          end
        end
      end
      S_TX: begin
        if (r_txleft != 2'd0) begin
          if (txd_ready && !r_txd_strobe) begin
            w_txd_n        = (r_txleft == 2'd2) ? r_buf[DATA_WIDTH-1 -: 8] : r_buf[7:0];
            w_txd_strobe_n = 1'b1;
            w_txleft_n     = r_txleft - 2'd1;
          end
        end else if (r_words != 8'd0) begin
          w_words_n = r_words - 8'd1;
          w_addr_n  = r_addr + ADDR_WIDTH'(2);
          w_state_n = S_MEM_REQ;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (rxd_strobe && (r_state inside {S_MEM_REQ, S_MEM_WAIT, S_TX})) begin
      w_overrun_n = 1'b1;
    end
    w_busy_n = (w_state_n != S_IDLE);
  end

  assign txd           = r_txd;
  assign txd_strobe    = r_txd_strobe;
  assign busy          = r_busy;
  assign overrun       = r_overrun;
  assign sd.sd_addr    = r_addr;
  assign sd.sd_wr_data = r_wdata;
  assign sd.sd_we      = r_we;
  assign sd.sd_enable  = r_en;

endmodule
